pipe_ctrl: RTL
==============

# pipe_ctrl

Central sequencing controller for the 5-stage CPU pipeline. It drives the enable and flush inputs of the PC register and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers, each of which is an enable register with synchronous clear. It resolves load-use hazards, taken-branch flushes, multi-cycle data-memory waits and halt/resume, and keeps saturating stall and flush statistics for the debug console.

## Interface

- `REG_AW`, 5: register-address width.
- `TIMEOUT`, 255: maximum wait cycles for a data-memory acknowledge before error; must be ≥ 1.
- `CNT_W`, 32: statistics counter width.

- `clk` in 1: the single clock for the block.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `id_rs1`, `id_rs2` in REG_AW: source registers of the instruction in ID.
- `id_use_rs1`, `id_use_rs2` in 1: the ID instruction actually reads that source.
- `ex_memread` in 1: the instruction in EX is a load.
- `ex_rd` in REG_AW: destination register of the instruction in EX.
- `ex_br_taken` in 1: the branch or jump in EX is taken; the PC mux selects its target.
- `mem_req` in 1: the MEM-stage instruction is accessing data memory.
- `mem_ack` in 1: data memory completes the access this cycle.
- `wb_halt` in 1: a halt instruction is in WB.
- `resume` in 1: single-cycle pulse from the console that leaves HALTED.
- `pc_en`, `ifid_en`, `idex_en`, `exmem_en`, `memwb_en` out 1 each: register enables.
- `ifid_flush`, `idex_flush`, `exmem_flush`, `memwb_flush` out 1 each: synchronous clear to the pipeline registers (bubble).
- `halted` out 1: the controller is in HALTED.
- `mem_err` out 1: sticky flag, set by a memory timeout and cleared only by reset.
- `stall_cnt`, `flush_cnt` out CNT_W each: saturating statistics counters.

## Operation

- FSM states: RUN, MEM_WAIT, HALTED. Reset state is RUN.
- Load-use condition: `ex_memread && ex_rd!=0 && ((id_use_rs1 && id_rs1==ex_rd) || (id_use_rs2 && id_rs2==ex_rd))`.
- Stall and flush outputs are combinational from the state and inputs. The counters and flags are registered.
- Decisions in RUN, by priority (the first match applies):
  1. `wb_halt`: all enables 0, no flushes. The FSM moves to HALTED.
  2. `mem_req && !mem_ack`: `pc_en`, `ifid_en`, `idex_en` and `exmem_en` are 0. `memwb_en` = 1 and `memwb_flush` = 1, which inserts a bubble into WB. The FSM moves to MEM_WAIT and the wait counter is loaded with 1.
  3. `ex_br_taken`: all enables 1, with `ifid_flush` = 1 and `idex_flush` = 1. A branch and a load-use in the same cycle resolve as a branch only; the ID instruction is wrong-path.
  4. Load-use: `pc_en` = 0 and `ifid_en` = 0. `idex_en` = 1 and `idex_flush` = 1. EX/MEM and MEM/WB advance normally.
  5. Otherwise all enables are 1 and all flushes are 0.
- MEM_WAIT:
  - The cycle after entry, and every cycle while `!mem_ack`, gets the same freeze as rule 2. The wait counter increments.
  - When `mem_ack` = 1, the RUN rules 3 to 5 apply that same cycle and the FSM returns to RUN. A branch held in ID/EX is therefore flushed on the cycle the pipeline advances.
  - If the wait counter reaches TIMEOUT without an ack: `mem_err` is set, the FSM moves to HALTED and all enables are 0.
- HALTED:
  - All enables are 0 and all flushes are 0. `halted` = 1.
  - On `resume` (and `!mem_err`), the FSM moves to RUN next cycle. `resume` is ignored while `mem_err` = 1.
  - `wb_halt` is ignored in the resume cycle. The halt instruction is cleared because `memwb_flush` = 1 on the first RUN cycle after resume.
- `stall_cnt` increments on every cycle with `pc_en` = 0 outside HALTED.
- `flush_cnt` increments on every cycle with `ifid_flush` = 1 caused by a branch.
- Both counters saturate at 2^CNT_W − 1 and never wrap.
- Reset (`rst_n` = 0):
  - The FSM goes to RUN immediately. The counters, `mem_err` and the wait counter are 0.
  - While reset is held, all enables are 0 and all flushes are 1, so the pipeline registers clear on each clock edge.
  - Reset mid-MEM_WAIT or mid-HALTED abandons that state with no residual effect.

## Timing

- Hazard response takes zero cycles: outputs react combinationally in the same cycle as the triggering inputs.
- Load-use costs exactly 1 bubble cycle.
- A taken branch costs 2 flushed slots.
- A memory access with ack in cycle N after the request (N ≥ 1) stalls for N cycles. An ack in the same cycle as the request (N = 0) causes no stall.
- `halted` and `mem_err` are registered. They change one edge after the event.
- The statistics counters update on the clock edge ending the qualifying cycle.

## Structure

- `pipe_pkg` holds the FSM state enum (`ST_RUN`, `ST_MEM_WAIT`, `ST_HALTED`) and `REG_AW_DEF`. These are shared with the hazard/forwarding unit.
- One sub-module, `sat_counter` (parameter WIDTH; ports clk, rst_n, inc, count), is instantiated twice.
- The FSM, hazard compare and output decode live in `pipe_ctrl`.

## Test plan

- Load-use: `ex_memread` = 1, `ex_rd` = 5, `id_rs1` = 5, `id_use_rs1` = 1 for 1 cycle. Expect `pc_en` = 0, `ifid_en` = 0, `idex_flush` = 1, `stall_cnt` = 1. Repeat with `ex_rd` = 0 and expect no stall.
- Branch plus load-use in the same cycle. Expect `ifid_flush` = 1, `idex_flush` = 1, `pc_en` = 1, `flush_cnt` +1, `stall_cnt` unchanged.
- `mem_req` = 1 with `mem_ack` after 3 cycles. Expect 3 frozen cycles with `memwb_flush` = 1, then an advance on the ack cycle, and `stall_cnt` = 3. Also apply `ex_br_taken` = 1 throughout and expect the flush only on the ack cycle.
- TIMEOUT = 4 with no ack. Expect `mem_err` = 1 and `halted` = 1 after the 4th wait cycle. A later `resume` is ignored. `rst_n` pulse clears everything.
- `wb_halt` = 1. Expect `halted` = 1 next edge and all enables 0. `resume` pulse: RUN next cycle with `memwb_flush` = 1.
- Counter saturation with CNT_W = 3 and 10 load-use stalls. Expect `stall_cnt` to hold at 7. Assert `rst_n` = 0 asynchronously mid-MEM_WAIT: expect immediate RUN, counters at 0, and all flushes at 1.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline-control types: FSM state encoding and default register-address width.
// Also used by the hazard/forwarding unit.
package pipe_pkg;

  localparam int unsigned REG_AW_DEF = 5;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_MEM_WAIT,
    ST_HALTED
  } pipe_state_e;

  typedef struct packed {
    logic pc;
    logic ifid;
    logic idex;
    logic exmem;
    logic memwb;
  } pipe_en_t;

  typedef struct packed {
    logic ifid;
    logic idex;
    logic exmem;
    logic memwb;
  } pipe_flush_t;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at its all-ones value instead of wrapping.
module sat_counter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (inc && (count_q != '1)) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipe_ctrl.sv
// 5-stage pipeline sequencer: load-use stalls, branch flushes, data-memory waits with timeout,
// halt/resume, and saturating stall/flush statistics.
module pipe_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned REG_AW  = REG_AW_DEF,
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic              ex_memread,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_br_taken,
  input  logic              mem_req,
  input  logic              mem_ack,
  input  logic              wb_halt,
  input  logic              resume,
  output logic              pc_en,
  output logic              ifid_en,
  output logic              idex_en,
  output logic              exmem_en,
  output logic              memwb_en,
  output logic              ifid_flush,
  output logic              idex_flush,
  output logic              exmem_flush,
  output logic              memwb_flush,
  output logic              halted,
  output logic              mem_err,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam int unsigned     WaitW   = $clog2(TIMEOUT + 1);
  localparam logic [WaitW-1:0] WaitMax = WaitW'(TIMEOUT);

  pipe_state_e      state_q, state_d;
  logic [WaitW-1:0] wait_q, wait_d;
  logic             mem_err_q, mem_err_d;
  logic             resumed_q, resumed_d;
  logic             load_use, advance, br_flush;
  pipe_en_t         en;
  pipe_flush_t      fl;

  assign load_use = ex_memread && (ex_rd != '0) &&
                    ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));

  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    mem_err_d = mem_err_q;
    en        = '0;
    fl        = '0;
    advance   = 1'b0;
    br_flush  = 1'b0;

    unique case (state_q)
      ST_RUN: begin
        // The halt still sitting in WB right after a resume must not re-halt us.
        if (wb_halt && !resumed_q) begin
          state_d = ST_HALTED;
        end else if (mem_req && !mem_ack) begin
          en.memwb = 1'b1;
          fl.memwb = 1'b1;
          state_d  = ST_MEM_WAIT;
          wait_d   = WaitW'(1);
        end else begin
          advance = 1'b1;
        end
      end
      ST_MEM_WAIT: begin
        if (mem_ack) begin
          advance = 1'b1;
          state_d = ST_RUN;
          wait_d  = '0;
        end else if (wait_q == WaitMax) begin
          mem_err_d = 1'b1;
          state_d   = ST_HALTED;
          wait_d    = '0;
        end else begin
          en.memwb = 1'b1;
          fl.memwb = 1'b1;
          wait_d   = wait_q + 1'b1;
        end
      end
      ST_HALTED: begin
        if (resume && !mem_err_q) begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase

    if (advance) begin
      if (ex_br_taken) begin
        en       = '1;
        fl.ifid  = 1'b1;
        fl.idex  = 1'b1;
        br_flush = 1'b1;
      end else if (load_use) begin
        en.idex  = 1'b1;
        en.exmem = 1'b1;
        en.memwb = 1'b1;
        fl.idex  = 1'b1;
      end else begin
        en = '1;
      end
    end

    if (resumed_q) begin
      fl.memwb = 1'b1;
    end

    // Hold every pipeline register in clear for as long as reset is asserted.
    if (!rst_n) begin
      en = '0;
      fl = '1;
    end
  end

  assign resumed_d = (state_q == ST_HALTED) && (state_d == ST_RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_RUN;
      wait_q    <= '0;
      mem_err_q <= 1'b0;
      resumed_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      mem_err_q <= mem_err_d;
      resumed_q <= resumed_d;
    end
  end

  sat_counter #(
    .WIDTH (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (!en.pc && (state_q != ST_HALTED)),
    .count (stall_cnt)
  );

  sat_counter #(
    .WIDTH (CNT_W)
  ) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (br_flush),
    .count (flush_cnt)
  );

  assign pc_en       = en.pc;
  assign ifid_en     = en.ifid;
  assign idex_en     = en.idex;
  assign exmem_en    = en.exmem;
  assign memwb_en    = en.memwb;
  assign ifid_flush  = fl.ifid;
  assign idex_flush  = fl.idex;
  assign exmem_flush = fl.exmem;
  assign memwb_flush = fl.memwb;
  assign halted      = (state_q == ST_HALTED);
  assign mem_err     = mem_err_q;

endmodule
